// File: rtl/dll_seq_pkg.sv
// Shared definitions for the DLL lock sequencer.
//   seq_state_t : sequencer FSM states
//   DRAIN_CYC   : cycles the DLL stays enabled after clk_sel drops on shutdown
//   DIV_W       : width of the DLL feedback division ratio
//   cnt_w()     : bits needed for a counter holding 0..max_val
package dll_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RST_HOLD,
        ST_SETTLE,
        ST_MEASURE,
        ST_LOCKED,
        ST_DCO_RUN,
        ST_DRAIN,
        ST_FAIL
    } seq_state_t;

    localparam int unsigned DRAIN_CYC = 4;
    localparam int unsigned DIV_W     = 5;

    function automatic int unsigned cnt_w(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/dll_freq_meter.sv
// Frequency meter for the DLL feedback toggle.
//   clock         in  reference clock
//   reset         in  synchronous active-high reset
//   run           in  1 = windows running; 0 = window/count cleared
//   div           in  latched DLL division ratio
//   fb_toggle     in  asynchronous divided DLL clock (toggle)
//   verdict_valid out one-cycle strobe, the cycle after a window ends
//   verdict_good  out window edge count within TOL of expected
module dll_freq_meter
    import dll_seq_pkg::*;
#(
    parameter int unsigned WINDOW      = 256,
    parameter int unsigned FB_DIV_LOG2 = 6,
    parameter int unsigned TOL         = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             run,
    input  logic [DIV_W-1:0] div,
    input  logic             fb_toggle,
    output logic             verdict_valid,
    output logic             verdict_good
);

    localparam int unsigned PH_W = $clog2(WINDOW);
    localparam int unsigned EC_W = cnt_w(WINDOW);
    localparam int unsigned EX_W = DIV_W + PH_W + 1;

    logic [2:0]      sync;
    logic            fb_edge;
    logic [PH_W-1:0] phase;
    logic [EC_W-1:0] edges;
    logic [EC_W-1:0] total;
    logic [EX_W-1:0] wide_div;
    logic [EX_W-1:0] expected;
    logic [EX_W-1:0] count_w;
    logic [EX_W-1:0] diff;
    logic            good;

    // sync[1:0] is the synchroniser; sync[2] only delays for edge detect
    assign fb_edge = sync[2] ^ sync[1];

    always_comb begin
        total = edges;
        if (fb_edge && (edges != '1)) begin
            total = edges + 1'b1;
        end
        wide_div = EX_W'(div);
        expected = (wide_div << PH_W) >> FB_DIV_LOG2;
        count_w  = EX_W'(total);
        diff     = (count_w >= expected) ? (count_w - expected) : (expected - count_w);
        good     = (diff <= EX_W'(TOL));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync <= '0;
        end else begin
            sync <= {sync[1:0], fb_toggle};
        end
    end

    // The last cycle's edge is folded into the verdict; the next window
    // starts counting on the cycle the verdict is presented.
    always_ff @(posedge clock) begin
        if (reset || !run) begin
            phase         <= '0;
            edges         <= '0;
            verdict_valid <= 1'b0;
            verdict_good  <= 1'b0;
        end else begin
            phase         <= phase + 1'b1;
            verdict_valid <= (phase == PH_W'(WINDOW - 1));
            if (phase == PH_W'(WINDOW - 1)) begin
                verdict_good <= good;
                edges        <= '0;
            end else begin
                edges <= total;
            end
        end
    end

endmodule

// File: rtl/dll_lock_sequencer.sv
// DLL start-up / supervision sequencer, clocked by the reference oscillator.
//   clock, reset           reference clock, synchronous active-high reset
//   cfg_enable             level: 1 = bring up DLL, 0 = shut down
//   cfg_dco, cfg_div       mode and division ratio, sampled when leaving IDLE
//   fb_toggle              asynchronous divided DLL clock
//   dll_enable/resetb/dco  DLL controls
//   dll_div                latched division ratio
//   clk_sel                core clock mux select (1 = DLL clock)
//   locked                 frequency lock (never set in DCO mode)
//   fail                   sticky timeout / illegal ratio flag
//   lock_lost              one-cycle pulse on loss of lock
module dll_lock_sequencer
    import dll_seq_pkg::*;
#(
    parameter int unsigned RST_CYC        = 16,
    parameter int unsigned SETTLE_CYC     = 1024,
    parameter int unsigned WINDOW         = 256,
    parameter int unsigned FB_DIV_LOG2    = 6,
    parameter int unsigned TOL            = 2,
    parameter int unsigned LOCK_WINDOWS   = 4,
    parameter int unsigned UNLOCK_WINDOWS = 2,
    parameter int unsigned MAX_WINDOWS    = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cfg_enable,
    input  logic             cfg_dco,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic             fb_toggle,
    output logic             dll_enable,
    output logic             dll_resetb,
    output logic             dll_dco,
    output logic [DIV_W-1:0] dll_div,
    output logic             clk_sel,
    output logic             locked,
    output logic             fail,
    output logic             lock_lost
);

    localparam int unsigned CNT_W  = cnt_w(RST_CYC + SETTLE_CYC + DRAIN_CYC);
    localparam int unsigned GOOD_W = cnt_w(LOCK_WINDOWS);
    localparam int unsigned BAD_W  = cnt_w(UNLOCK_WINDOWS);
    localparam int unsigned TOT_W  = cnt_w(MAX_WINDOWS);

    seq_state_t        state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [GOOD_W-1:0] good_cnt, good_cnt_n;
    logic [BAD_W-1:0]  bad_cnt, bad_cnt_n;
    logic [TOT_W-1:0]  win_tot, win_tot_n;

    logic             en_n, rb_n, dco_n, clk_n, lk_n, fail_n, lost_n;
    logic [DIV_W-1:0] div_n;

    logic meter_run, verdict_valid, verdict_good;

    assign meter_run = (state == ST_MEASURE) || (state == ST_LOCKED);

    dll_freq_meter #(
        .WINDOW      (WINDOW),
        .FB_DIV_LOG2 (FB_DIV_LOG2),
        .TOL         (TOL)
    ) u_meter (
        .clock         (clock),
        .reset         (reset),
        .run           (meter_run),
        .div           (dll_div),
        .fb_toggle     (fb_toggle),
        .verdict_valid (verdict_valid),
        .verdict_good  (verdict_good)
    );

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        good_cnt_n = good_cnt;
        bad_cnt_n  = bad_cnt;
        win_tot_n  = win_tot;
        dco_n      = dll_dco;
        div_n      = dll_div;

        case (state)
            ST_IDLE: begin
                if (cfg_enable) begin
                    dco_n = cfg_dco;
                    div_n = cfg_div;
                    cnt_n = '0;
                    if (cfg_div == '0)  state_n = ST_FAIL;
                    else if (cfg_dco)   state_n = ST_DCO_RUN;
                    else                state_n = ST_RST_HOLD;
                end
            end
            ST_RST_HOLD: begin
                if (!cfg_enable) begin
                    state_n = ST_DRAIN;
                    cnt_n   = '0;
                end else if (cnt == CNT_W'(RST_CYC - 1)) begin
                    state_n = ST_SETTLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ST_SETTLE: begin
                if (!cfg_enable) begin
                    state_n = ST_DRAIN;
                    cnt_n   = '0;
                end else if (cnt == CNT_W'(SETTLE_CYC - 1)) begin
                    state_n    = ST_MEASURE;
                    cnt_n      = '0;
                    good_cnt_n = '0;
                    win_tot_n  = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ST_MEASURE: begin
                if (!cfg_enable) begin
                    state_n = ST_DRAIN;
                    cnt_n   = '0;
                end else if (verdict_valid) begin
                    if (verdict_good && (good_cnt == GOOD_W'(LOCK_WINDOWS - 1))) begin
                        state_n   = ST_LOCKED;
                        bad_cnt_n = '0;
                    end else begin
                        good_cnt_n = verdict_good ? good_cnt + 1'b1 : '0;
                        if (win_tot == TOT_W'(MAX_WINDOWS - 1)) state_n = ST_FAIL;
                        else                                   win_tot_n = win_tot + 1'b1;
                    end
                end
            end
            ST_LOCKED: begin
                if (!cfg_enable) begin
                    state_n = ST_DRAIN;
                    cnt_n   = '0;
                end else if (verdict_valid) begin
                    if (verdict_good) begin
                        bad_cnt_n = '0;
                    end else if (bad_cnt == BAD_W'(UNLOCK_WINDOWS - 1)) begin
                        state_n = ST_RST_HOLD;
                        cnt_n   = '0;
                    end else begin
                        bad_cnt_n = bad_cnt + 1'b1;
                    end
                end
            end
            ST_DCO_RUN: begin
                // cnt runs through the reset and settle phases, then parks
                if (!cfg_enable) begin
                    state_n = ST_DRAIN;
                    cnt_n   = '0;
                end else if (cnt != CNT_W'(RST_CYC + SETTLE_CYC)) begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (cnt == CNT_W'(DRAIN_CYC - 1)) begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ST_FAIL: begin
                if (!cfg_enable) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase

        // Outputs are decoded from the next state so they leave a register
        en_n   = 1'b0;
        rb_n   = 1'b0;
        clk_n  = 1'b0;
        lk_n   = 1'b0;
        fail_n = 1'b0;
        lost_n = (state == ST_LOCKED) && (state_n == ST_RST_HOLD);

        case (state_n)
            ST_IDLE: begin
                dco_n = 1'b0;
                div_n = '0;
            end
            ST_RST_HOLD: en_n = 1'b1;
            ST_SETTLE, ST_MEASURE: begin
                en_n = 1'b1;
                rb_n = 1'b1;
            end
            ST_LOCKED: begin
                en_n  = 1'b1;
                rb_n  = 1'b1;
                clk_n = 1'b1;
                lk_n  = 1'b1;
            end
            ST_DCO_RUN: begin
                en_n  = 1'b1;
                rb_n  = (cnt_n >= CNT_W'(RST_CYC));
                clk_n = (cnt_n >= CNT_W'(RST_CYC + SETTLE_CYC));
            end
            ST_DRAIN: begin
                // keep the DLL as it was while the mux switches away
                en_n = dll_enable;
                rb_n = dll_resetb;
            end
            ST_FAIL: fail_n = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            good_cnt   <= '0;
            bad_cnt    <= '0;
            win_tot    <= '0;
            dll_enable <= 1'b0;
            dll_resetb <= 1'b0;
            dll_dco    <= 1'b0;
            dll_div    <= '0;
            clk_sel    <= 1'b0;
            locked     <= 1'b0;
            fail       <= 1'b0;
            lock_lost  <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            good_cnt   <= good_cnt_n;
            bad_cnt    <= bad_cnt_n;
            win_tot    <= win_tot_n;
            dll_enable <= en_n;
            dll_resetb <= rb_n;
            dll_dco    <= dco_n;
            dll_div    <= div_n;
            clk_sel    <= clk_n;
            locked     <= lk_n;
            fail       <= fail_n;
            lock_lost  <= lost_n;
        end
    end

endmodule

// File: tb/tb_dll_lock_sequencer.sv
// Bench for dll_lock_sequencer: stimulus queues the expected output vector
// and edge number of every output change; a negedge monitor pops and checks.
`timescale 1ns/1ps
module tb_dll_lock_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       cfg_enable = 1'b0;
    logic       cfg_dco = 1'b0;
    logic [4:0] cfg_div = '0;
    logic       fb_toggle = 1'b0;
    logic       dll_enable, dll_resetb, dll_dco, clk_sel, locked, fail, lock_lost;
    logic [4:0] dll_div;

    dll_lock_sequencer dut (
        .clock      (clock),
        .reset      (reset),
        .cfg_enable (cfg_enable),
        .cfg_dco    (cfg_dco),
        .cfg_div    (cfg_div),
        .fb_toggle  (fb_toggle),
        .dll_enable (dll_enable),
        .dll_resetb (dll_resetb),
        .dll_dco    (dll_dco),
        .dll_div    (dll_div),
        .clk_sel    (clk_sel),
        .locked     (locked),
        .fail       (fail),
        .lock_lost  (lock_lost)
    );

    always #5 clock = ~clock;

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // fb model: fb_rate toggles per 256 reference cycles, evenly spread
    int unsigned fb_rate = 32;
    int unsigned fb_acc  = 0;
    always @(negedge clock) begin
        fb_acc = fb_acc + fb_rate;
        if (fb_acc >= 256) begin
            fb_acc    = fb_acc - 256;
            fb_toggle = ~fb_toggle;
        end
    end

    typedef struct {
        logic [11:0] vec;
        int unsigned cyc;
    } exp_t;
    exp_t sb[$];

    logic [11:0] obs;
    assign obs = {lock_lost, fail, locked, clk_sel, dll_div, dll_dco, dll_resetb, dll_enable};

    function automatic logic [11:0] mk(input bit en, input bit rb, input bit dco,
                                       input logic [4:0] div, input bit cs,
                                       input bit lk, input bit fl, input bit lost);
        return {lost, fl, lk, cs, div, dco, rb, en};
    endfunction

    task automatic push(input logic [11:0] v, input int unsigned c);
        exp_t e;
        e.vec = v;
        e.cyc = c;
        sb.push_back(e);
    endtask

    task automatic wait_cyc(input int unsigned target);
        while (cyc < target) @(negedge clock);
    endtask

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    logic [11:0] prev = '1;

    always @(negedge clock) begin
        if (obs !== prev) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_change cyc=%0d got=%h required=no change", cyc, obs);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (obs !== e.vec || cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL output_event got=%h@%0d required=%h@%0d", obs, cyc, e.vec, e.cyc);
                end
            end
            prev = obs;
        end
    end

    localparam logic [11:0] ZERO = 12'h000;

    initial begin
        int unsigned e0, d, l2;

        // reset state
        push(ZERO, 1);
        wait_cyc(3);
        reset = 1'b0;

        // 1: exact ratio, div=8 -> 32 edges per window, lock after 4 windows
        wait_cyc(5);
        cfg_div    = 5'd8;
        cfg_enable = 1'b1;
        e0 = cyc + 1;
        push(mk(1, 0, 0, 8, 0, 0, 0, 0), e0);
        push(mk(1, 1, 0, 8, 0, 0, 0, 0), e0 + 16);
        push(mk(1, 1, 0, 8, 1, 1, 0, 0), e0 + 2065);
        @(negedge clock);
        cfg_div = 5'd5;          // ignored while active
        cfg_dco = 1'b1;
        wait_cyc(e0 + 2075);

        // 5: drop enable while locked
        cfg_enable = 1'b0;
        d = cyc + 1;
        push(mk(1, 1, 0, 8, 0, 0, 0, 0), d);
        push(ZERO, d + 4);
        wait_cyc(d + 10);

        // 2: 35 edges per window -> FAIL after 64 windows
        cfg_dco    = 1'b0;
        cfg_div    = 5'd8;
        fb_rate    = 35;
        cfg_enable = 1'b1;
        e0 = cyc + 1;
        push(mk(1, 0, 0, 8, 0, 0, 0, 0), e0);
        push(mk(1, 1, 0, 8, 0, 0, 0, 0), e0 + 16);
        push(mk(0, 0, 0, 8, 0, 0, 1, 0), e0 + 17425);
        wait_cyc(e0 + 17435);
        cfg_enable = 1'b0;
        push(ZERO, cyc + 1);
        wait_cyc(cyc + 10);

        // 3: lock, stop fb -> lock loss, relock at 30 edges (tolerance edge)
        fb_rate    = 32;
        cfg_enable = 1'b1;
        e0 = cyc + 1;
        push(mk(1, 0, 0, 8, 0, 0, 0, 0), e0);
        push(mk(1, 1, 0, 8, 0, 0, 0, 0), e0 + 16);
        push(mk(1, 1, 0, 8, 1, 1, 0, 0), e0 + 2065);
        wait_cyc(e0 + 2065);
        fb_rate = 0;
        l2 = e0 + 2577;
        push(mk(1, 0, 0, 8, 0, 0, 0, 1), l2);
        push(mk(1, 0, 0, 8, 0, 0, 0, 0), l2 + 1);
        push(mk(1, 1, 0, 8, 0, 0, 0, 0), l2 + 16);
        push(mk(1, 1, 0, 8, 1, 1, 0, 0), l2 + 2065);
        wait_cyc(l2 + 5);
        fb_rate = 30;
        wait_cyc(l2 + 2075);
        cfg_enable = 1'b0;
        d = cyc + 1;
        push(mk(1, 1, 0, 8, 0, 0, 0, 0), d);
        push(ZERO, d + 4);
        wait_cyc(d + 10);

        // 4: DCO mode, bad fb ignored
        cfg_dco    = 1'b1;
        cfg_div    = 5'd8;
        fb_rate    = 35;
        cfg_enable = 1'b1;
        e0 = cyc + 1;
        push(mk(1, 0, 1, 8, 0, 0, 0, 0), e0);
        push(mk(1, 1, 1, 8, 0, 0, 0, 0), e0 + 16);
        push(mk(1, 1, 1, 8, 1, 0, 0, 0), e0 + 1040);
        wait_cyc(e0 + 1300);

        // drop, re-raise during DRAIN (waits for IDLE), reset mid-SETTLE
        cfg_enable = 1'b0;
        d = cyc + 1;
        push(mk(1, 1, 1, 8, 0, 0, 0, 0), d);
        @(negedge clock);
        cfg_dco    = 1'b0;
        cfg_div    = 5'd8;
        cfg_enable = 1'b1;
        push(ZERO, d + 4);
        push(mk(1, 0, 0, 8, 0, 0, 0, 0), d + 5);
        push(mk(1, 1, 0, 8, 0, 0, 0, 0), d + 21);
        wait_cyc(d + 100);
        reset      = 1'b1;
        cfg_enable = 1'b0;
        push(ZERO, d + 101);
        wait_cyc(d + 104);
        reset = 1'b0;
        wait_cyc(d + 110);

        // 6: cfg_div = 0 -> immediate FAIL, cleared when enable drops
        cfg_div    = 5'd0;
        cfg_enable = 1'b1;
        push(mk(0, 0, 0, 0, 0, 0, 1, 0), cyc + 1);
        wait_cyc(cyc + 10);
        cfg_enable = 1'b0;
        push(ZERO, cyc + 1);
        wait_cyc(cyc + 10);

        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL pending_events got=%0d required=0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
